sccb_init_seq: RTL and testbench

SCCB_INIT_SEQ -- requirements
Module: sccb_init_seq

---
 rtl/sccb_init_seq.sv | 172 +++++++++++++++++
 tb/tb_sccb_init_seq.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_init_seq.sv
// Walks a register table out of a synchronous ROM and pushes each entry to an
// SCCB controller over single-beat AXI4 writes, after configuring the controller.
module sccb_init_seq #(
    parameter logic [31:0] CONF_BASE_ADDR   = 32'h2000_0000,
    parameter logic [31:0] TX_BASE_ADDR     = 32'h2100_0000,
    parameter logic [6:0]  SLV_DVC_ADDR     = 7'h21,
    parameter logic [7:0]  PRESCALER        = 8'd1,
    parameter int unsigned TBL_AW           = 8,
    parameter int unsigned MST_ID_W         = 5,
    parameter int unsigned AXI_ID           = 0,
    parameter int unsigned TRANS_DATA_LEN_W = 8,
    parameter int unsigned TRANS_RESP_W     = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o,
    output logic [TBL_AW:0]             entry_cnt_o,
    output logic [TBL_AW-1:0]           tbl_addr_o,
    input  logic [15:0]                 tbl_data_i,
    output logic [MST_ID_W-1:0]         m_awid_o,
    output logic [31:0]                 m_awaddr_o,
    output logic [TRANS_DATA_LEN_W-1:0] m_awlen_o,
    output logic                        m_awvalid_o,
    input  logic                        m_awready_i,
    output logic [7:0]                  m_wdata_o,
    output logic                        m_wlast_o,
    output logic                        m_wvalid_o,
    input  logic                        m_wready_i,
    input  logic [MST_ID_W-1:0]         m_bid_i,
    input  logic [TRANS_RESP_W-1:0]     m_bresp_i,
    input  logic                        m_bvalid_i,
    output logic                        m_bready_o
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CFG_DVC,
        S_CFG_PSC,
        S_FETCH,
        S_DECODE,
        S_TX_SUB,
        S_TX_DAT,
        S_TX_CTL,
        S_DONE,
        S_ERR
    } state_e;

    state_e              state_q, state_d;
    logic [TBL_AW-1:0]   idx_q, idx_d;
    logic [TBL_AW:0]     cnt_q, cnt_d;
    logic [15:0]         entry_q, entry_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic [31:0]         awaddr_q, awaddr_d;
    logic [7:0]          wdata_q, wdata_d;

    logic wr_st, bready, wr_done, wr_fail, wr_ok;

    function automatic logic is_wr(input state_e s);
        return s inside {S_CFG_DVC, S_CFG_PSC, S_TX_SUB, S_TX_DAT, S_TX_CTL};
    endfunction

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        entry_d   = entry_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;

        wr_st   = is_wr(state_q);
        bready  = wr_st && !awvalid_q && !wvalid_q;
        wr_done = bready && m_bvalid_i;
        // A response tagged with a foreign ID is treated as a failed write.
        wr_fail = wr_done && ((m_bresp_i != '0) || (m_bid_i != MST_ID_W'(AXI_ID)));
        wr_ok   = wr_done && !wr_fail;

        if (wr_st) begin
            if (awvalid_q && m_awready_i) awvalid_d = 1'b0;
            if (wvalid_q && m_wready_i)   wvalid_d  = 1'b0;
        end

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) begin
                    state_d = S_CFG_DVC;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_CFG_DVC: if (wr_ok) state_d = S_CFG_PSC;
            S_CFG_PSC: if (wr_ok) state_d = S_FETCH;
            S_FETCH:   state_d = S_DECODE;
            S_DECODE: begin
                entry_d = tbl_data_i;
                state_d = (tbl_data_i == 16'hFFFF) ? S_DONE : S_TX_SUB;
            end
            S_TX_SUB:  if (wr_ok) state_d = S_TX_DAT;
            S_TX_DAT:  if (wr_ok) state_d = S_TX_CTL;
            S_TX_CTL: begin
                if (wr_ok) begin
                    cnt_d = cnt_q + 1'b1;
                    if (idx_q == '1) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (wr_fail) state_d = S_ERR;

        // Every write state is entered from a different state, so entry is the launch point.
        if (is_wr(state_d) && (state_d != state_q)) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            case (state_d)
                S_CFG_DVC: begin awaddr_d = CONF_BASE_ADDR;         wdata_d = {1'b0, SLV_DVC_ADDR}; end
                S_CFG_PSC: begin awaddr_d = CONF_BASE_ADDR + 32'd1; wdata_d = PRESCALER;            end
                S_TX_SUB:  begin awaddr_d = TX_BASE_ADDR + 32'd1;   wdata_d = entry_d[15:8];        end
                S_TX_DAT:  begin awaddr_d = TX_BASE_ADDR + 32'd2;   wdata_d = entry_d[7:0];         end
                S_TX_CTL:  begin awaddr_d = TX_BASE_ADDR;           wdata_d = 8'h03;                end
                default:   begin awaddr_d = awaddr_q;               wdata_d = wdata_q;              end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            entry_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            entry_q   <= entry_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign busy_o      = !(state_q inside {S_IDLE, S_DONE, S_ERR});
    assign done_o      = (state_q == S_DONE);
    assign err_o       = (state_q == S_ERR);
    assign entry_cnt_o = cnt_q;
    assign tbl_addr_o  = idx_q;
    assign m_awid_o    = MST_ID_W'(AXI_ID);
    assign m_awaddr_o  = awaddr_q;
    assign m_awlen_o   = '0;
    assign m_awvalid_o = awvalid_q;
    assign m_wdata_o   = wdata_q;
    assign m_wlast_o   = wvalid_q;
    assign m_wvalid_o  = wvalid_q;
    assign m_bready_o  = bready;

endmodule

// File: tb/tb_sccb_init_seq.sv
// Bench for sccb_init_seq: table ROM and AXI slave models, a write-sequence
// model derived from the table contents, and a per-cycle protocol/compare process.
module tb_sccb_init_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, err;
    logic [2:0]  cnt;
    logic [1:0]  tbl_addr;
    logic [15:0] tbl_data;
    logic [4:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        awvalid, awready;
    logic [7:0]  wdata;
    logic        wlast, wvalid, wready;
    logic [4:0]  bid = 5'd0;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sccb_init_seq #(.TBL_AW(2)) dut (
        .clk(clk), .rst(rst), .start_i(start),
        .busy_o(busy), .done_o(done), .err_o(err), .entry_cnt_o(cnt),
        .tbl_addr_o(tbl_addr), .tbl_data_i(tbl_data),
        .m_awid_o(awid), .m_awaddr_o(awaddr), .m_awlen_o(awlen),
        .m_awvalid_o(awvalid), .m_awready_i(awready),
        .m_wdata_o(wdata), .m_wlast_o(wlast), .m_wvalid_o(wvalid), .m_wready_i(wready),
        .m_bid_i(bid), .m_bresp_i(bresp), .m_bvalid_i(bvalid), .m_bready_o(bready)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Synchronous table ROM, one-cycle read latency.
    logic [15:0] rom [4];
    always @(posedge clk) tbl_data <= rom[tbl_addr];

    // AXI slave: response one cycle after both channels have handshaken.
    int   err_at = -1;
    int   slv_n;
    logic sa, sw;
    always @(posedge clk) begin
        if (rst) begin
            sa <= 1'b0; sw <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00; slv_n <= 0;
        end else if (bvalid && bready) begin
            bvalid <= 1'b0; sa <= 1'b0; sw <= 1'b0; slv_n <= slv_n + 1;
        end else begin
            if (awvalid && awready) sa <= 1'b1;
            if (wvalid && wready)   sw <= 1'b1;
            if (!bvalid && (sa || (awvalid && awready)) && (sw || (wvalid && wready))) begin
                bvalid <= 1'b1;
                bresp  <= (slv_n == err_at) ? 2'b10 : 2'b00;
            end
        end
    end

    // Model: expected write list from the table contents.
    logic [31:0] exp_addr [$];
    logic [7:0]  exp_data [$];
    logic [31:0] obs_addr [$];
    logic [7:0]  obs_data [$];
    int          exp_ents;
    bit          exp_err;
    int          n_wr;

    task automatic load_model(input int e_at);
        int ents;
        ents = 0;
        exp_addr.delete(); exp_data.delete(); obs_addr.delete(); obs_data.delete();
        exp_addr.push_back(32'h2000_0000); exp_data.push_back(8'h21);
        exp_addr.push_back(32'h2000_0001); exp_data.push_back(8'h01);
        for (int i = 0; i < 4; i++) begin
            if (rom[i] == 16'hFFFF) break;
            exp_addr.push_back(32'h2100_0001); exp_data.push_back(rom[i][15:8]);
            exp_addr.push_back(32'h2100_0002); exp_data.push_back(rom[i][7:0]);
            exp_addr.push_back(32'h2100_0000); exp_data.push_back(8'h03);
            ents++;
        end
        exp_err = (e_at >= 0) && (e_at < exp_addr.size());
        if (exp_err) begin
            while (exp_addr.size() > e_at + 1) begin
                void'(exp_addr.pop_back()); void'(exp_data.pop_back());
            end
            ents = (e_at >= 2) ? (e_at - 2) / 3 : 0;
        end
        exp_ents = ents;
        err_at   = e_at;
        n_wr     = 0;
    endtask

    // Compare process: protocol rules every cycle, write contents on completion.
    logic        a_seen, w_seen, p_awv, p_awr, p_wv, p_wr, p_busy;
    logic [31:0] cap_addr, p_addr;
    logic [7:0]  cap_data, p_data;
    logic [1:0]  p_tbl;
    always @(negedge clk) begin
        if (rst) begin
            a_seen = 1'b0; w_seen = 1'b0; p_awv = 1'b0; p_wv = 1'b0; p_busy = 1'b0;
        end else begin
            chk("awlen", awlen, 0);
            chk("awid", awid, 0);
            if (wvalid) chk("wlast", wlast, 1);
            if (p_awv && !p_awr) begin
                chk("aw_hold", awvalid, 1);
                chk("aw_addr_stable", awaddr, p_addr);
            end
            if (p_wv && !p_wr) begin
                chk("w_hold", wvalid, 1);
                chk("w_data_stable", wdata, p_data);
            end
            if (bready) chk("bready_early", a_seen && w_seen, 1);
            if (a_seen) chk("aw_after_hs", awvalid, 0);
            if (w_seen) chk("w_after_hs", wvalid, 0);
            if (!a_seen && !w_seen) chk("valid_pair", awvalid, wvalid);
            if (busy && p_busy) chk("tbl_no_wrap", tbl_addr >= p_tbl, 1);
            chk("done_busy_excl", done && busy, 0);
            if (awvalid && awready) begin a_seen = 1'b1; cap_addr = awaddr; end
            if (wvalid && wready)   begin w_seen = 1'b1; cap_data = wdata;  end
            if (bvalid && bready) begin
                obs_addr.push_back(cap_addr); obs_data.push_back(cap_data);
                if (n_wr < exp_addr.size()) begin
                    chk("wr_addr", cap_addr, exp_addr[n_wr]);
                    chk("wr_data", cap_data, exp_data[n_wr]);
                end else begin
                    chk("write_count", n_wr + 1, exp_addr.size());
                end
                n_wr++;
                a_seen = 1'b0; w_seen = 1'b0;
            end
            p_awv = awvalid; p_awr = awready; p_addr = awaddr;
            p_wv = wvalid; p_wr = wready; p_data = wdata;
            p_tbl = tbl_addr; p_busy = busy;
        end
    end

    task automatic chk_quiet(input string tag);
        chk({tag, "_awvalid"}, awvalid, 0);
        chk({tag, "_wvalid"}, wvalid, 0);
        chk({tag, "_bready"}, bready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_cnt"}, cnt, 0);
        chk({tag, "_tbl_addr"}, tbl_addr, 0);
        chk({tag, "_awaddr"}, awaddr, 0);
        chk({tag, "_wdata"}, wdata, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_quiet("reset");
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run(input int poke);
        bit fin;
        fin = 1'b0;
        pulse_start();
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (c == poke) begin
                chk("busy_at_poke", busy, 1);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done || err) begin fin = 1'b1; break; end
        end
        start = 1'b0;
        chk("finish_timeout", fin, 1);
        chk("write_count", n_wr, exp_addr.size());
        chk("done_end", done, !exp_err);
        chk("err_end", err, exp_err);
        chk("entry_cnt_end", cnt, exp_ents);
        chk("busy_end", busy, 0);
    endtask

    task automatic wait_tx_dat(output bit found);
        found = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(posedge clk); #1;
            if (awvalid && awaddr == 32'h2100_0002) begin found = 1'b1; break; end
        end
        chk("tx_dat_found", found, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst = 1'b1; start = 1'b0; awready = 1'b1; wready = 1'b1;
        for (int i = 0; i < 4; i++) rom[i] = 16'hFFFF;
        do_reset();

        // Basic table, with a start pulse while busy that must be ignored.
        rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'hFFFF; rom[3] = 16'hFFFF;
        load_model(-1);
        run(10);
        chk("t1_nwr", obs_addr.size(), 8);
        chk("t1_cnt", cnt, 2);
        chk("t1_done", done, 1);
        if (obs_addr.size() == 8) begin
            chk("t1_a0", obs_addr[0], 32'h2000_0000); chk("t1_d0", obs_data[0], 8'h21);
            chk("t1_a1", obs_addr[1], 32'h2000_0001); chk("t1_d1", obs_data[1], 8'h01);
            chk("t1_a2", obs_addr[2], 32'h2100_0001); chk("t1_d2", obs_data[2], 8'h12);
            chk("t1_a3", obs_addr[3], 32'h2100_0002); chk("t1_d3", obs_data[3], 8'h80);
            chk("t1_a7", obs_addr[7], 32'h2100_0000); chk("t1_d7", obs_data[7], 8'h03);
            chk("t1_d6", obs_data[6], 8'h01);
        end

        // W channel stalled for 20 cycles during the first TX_DAT write.
        do_reset();
        load_model(-1);
        fork
            run(-1);
            begin
                bit f2;
                wait_tx_dat(f2);
                if (f2) begin
                    wready = 1'b0;
                    for (int i = 0; i < 20; i++) begin
                        @(posedge clk); #1;
                        chk("stall_awvalid", awvalid, 0);
                        chk("stall_wvalid", wvalid, 1);
                        chk("stall_wdata", wdata, 8'h80);
                        chk("stall_bready", bready, 0);
                    end
                    wready = 1'b1;
                end
            end
        join
        chk("t2_cnt", cnt, 2);

        // Error response on the second TX_SUB write, then restart.
        do_reset();
        load_model(5);
        run(-1);
        chk("t3_err", err, 1);
        chk("t3_cnt", cnt, 1);
        chk("t3_nwr", n_wr, 6);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("t3_no_aw", awvalid, 0);
            chk("t3_busy", busy, 0);
        end
        load_model(-1);
        run(-1);
        chk("t3r_cnt", cnt, 2);
        if (obs_addr.size() > 0) chk("t3r_first", obs_addr[0], 32'h2000_0000);

        // Reset pulsed while the TX_DAT write is in flight.
        do_reset();
        load_model(-1);
        pulse_start();
        wait_tx_dat(found);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_quiet("midrst");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("midrst_idle_busy", busy, 0);
            chk("midrst_idle_aw", awvalid, 0);
        end
        load_model(-1);
        run(-1);

        // No end marker: all four entries then stop without wrapping.
        do_reset();
        rom[0] = 16'h0A01; rom[1] = 16'h0B02; rom[2] = 16'h0C03; rom[3] = 16'h0D04;
        load_model(-1);
        run(-1);
        chk("t5_nwr", n_wr, 14);
        chk("t5_cnt", cnt, 4);
        chk("t5_tbl_addr", tbl_addr, 3);
        chk("t5_done", done, 1);
        if (obs_data.size() == 14) chk("t5_last_dat", obs_data[12], 8'h04);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
